// File: rtl/riscv_pkg.sv
// Shared RV64 definitions for the MEM stage: load/store funct3 encodings and a size decoder.
package riscv_pkg;

    localparam int XLEN     = 64;
    localparam int DW_BYTES = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic       valid;
        logic       is_signed;
        logic [3:0] n_bytes;
    } size_info_t;

    // Invalid encodings (111) decode to zero bytes with valid cleared.
    function automatic size_info_t size_decode(input logic [2:0] funct3);
        size_info_t info;
        info = '0;
        case (funct3)
            F3_B:    info = '{valid: 1'b1, is_signed: 1'b1, n_bytes: 4'd1};
            F3_H:    info = '{valid: 1'b1, is_signed: 1'b1, n_bytes: 4'd2};
            F3_W:    info = '{valid: 1'b1, is_signed: 1'b1, n_bytes: 4'd4};
            F3_D:    info = '{valid: 1'b1, is_signed: 1'b0, n_bytes: 4'd8};
            F3_BU:   info = '{valid: 1'b1, is_signed: 1'b0, n_bytes: 4'd1};
            F3_HU:   info = '{valid: 1'b1, is_signed: 1'b0, n_bytes: 4'd2};
            F3_WU:   info = '{valid: 1'b1, is_signed: 1'b0, n_bytes: 4'd4};
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// Lane select plus sign/zero extension of a raw doubleword into a 64-bit load result.
module load_extend
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] dw,
    input  logic [2:0]      lane,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    size_info_t      info;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep;
    logic            msb;

    always_comb begin
        info    = size_decode(funct3);
        shifted = dw >> {lane, 3'b000};
        keep    = '1;
        msb     = 1'b0;
        case (info.n_bytes)
            4'd1: begin keep = 64'h0000_0000_0000_00FF; msb = shifted[7];  end
            4'd2: begin keep = 64'h0000_0000_0000_FFFF; msb = shifted[15]; end
            4'd4: begin keep = 64'h0000_0000_FFFF_FFFF; msb = shifted[31]; end
            default: begin keep = '1; msb = 1'b0; end
        endcase
        // Sign bits fill everything above the kept lanes.
        if (!info.valid)
            result = '0;
        else
            result = (shifted & keep) | ((info.is_signed && msb) ? ~keep : '0);
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressed little-endian data memory: combinational loads, edge-committed stores.
module data_memory
    import riscv_pkg::*;
#(
    parameter int DEPTH_DW = 64,
    parameter int IDX_W    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] addr,
    input  logic [63:0] write_data,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    output logic [63:0] read_data,
    output logic        misaligned,
    output logic        misaligned_sticky,
    output logic [63:0] element1,
    output logic [63:0] element2,
    output logic [63:0] element3,
    output logic [63:0] element4,
    output logic [63:0] element5,
    output logic [63:0] element6,
    output logic [63:0] element7,
    output logic [63:0] element8
);

    logic [XLEN-1:0] mem_q [DEPTH_DW];
    logic [XLEN-1:0] mem_d [DEPTH_DW];
    logic            sticky_q, sticky_d;

    size_info_t      info;
    logic [IDX_W-1:0] idx;
    logic [2:0]      lane;
    logic [7:0]      base_mask;
    logic [7:0]      lane_mask;
    logic [XLEN-1:0] wr_shifted;
    logic [XLEN-1:0] ext_data;
    logic            store_en;
    logic            unused_bits;

    assign idx  = addr[IDX_W+2:3];
    assign lane = addr[2:0];
    assign info = size_decode(funct3);

    // Upper address bits are intentionally dropped so addresses wrap.
    assign unused_bits = ^{addr[XLEN-1:IDX_W+3]};

    load_extend u_load_extend (
        .dw     (mem_q[idx]),
        .lane   (lane),
        .funct3 (funct3),
        .result (ext_data)
    );

    always_comb begin
        misaligned = (mem_read || mem_write) && info.valid
                     && (|(lane & 3'(info.n_bytes - 4'd1)));
        read_data  = (mem_read && !misaligned) ? ext_data : '0;
    end

    // Stores accept only the signed-size encodings; the unsigned ones have no store form.
    always_comb begin
        case (info.n_bytes)
            4'd1:    base_mask = 8'h01;
            4'd2:    base_mask = 8'h03;
            4'd4:    base_mask = 8'h0F;
            4'd8:    base_mask = 8'hFF;
            default: base_mask = 8'h00;
        endcase
        lane_mask  = base_mask << lane;
        wr_shifted = write_data << {lane, 3'b000};
        store_en   = mem_write && !misaligned && info.valid && !funct3[2];
        sticky_d   = sticky_q | misaligned;
        mem_d      = mem_q;
        if (store_en) begin
            for (int b = 0; b < DW_BYTES; b++) begin
                if (lane_mask[b])
                    mem_d[idx][b*8 +: 8] = wr_shifted[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_DW; i++)
                mem_q[i] <= '0;
            sticky_q <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            sticky_q <= sticky_d;
        end
    end

    assign misaligned_sticky = sticky_q;
    assign element1 = mem_q[0];
    assign element2 = mem_q[1];
    assign element3 = mem_q[2];
    assign element4 = mem_q[3];
    assign element5 = mem_q[4];
    assign element6 = mem_q[5];
    assign element7 = mem_q[6];
    assign element8 = mem_q[7];

endmodule
